// File: rtl/mac_accum_drain_if.sv
// Handshake bundle between the MAC array result stream and the accumulate/drain block.
// The slave modport is the drain block's view; master is the producer/consumer side.
interface mac_accum_drain_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned N         = 16,
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 8
);
    logic [CNT_WIDTH-1:0]            cfg_beats;
    logic                            in_valid;
    logic                            in_ready;
    logic [N-1:0][2*WIDTH-1:0]       in_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [N-1:0][ACC_WIDTH-1:0]     out_data;
    logic [N-1:0]                    out_ovf;

    modport master (
        output cfg_beats, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  cfg_beats, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/mac_accum_drain.sv
// Accumulates groups of N-lane MAC result beats into saturating per-lane sums with sticky
// overflow flags, then holds each completed group on a valid/ready output until drained.
module mac_accum_drain #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned N         = 16,
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    mac_accum_drain_if.slave  bus
);
    localparam int unsigned SumW = ACC_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    if (ACC_WIDTH < 2 * WIDTH) begin : g_bad_acc_width
        $error("ACC_WIDTH must be at least 2*WIDTH");
    end

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    state_e                      state_q, state_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]        beats_q, beats_d;
    logic [N-1:0][ACC_WIDTH-1:0] acc_q, acc_d;
    logic [N-1:0]                ovf_q, ovf_d;
    logic [N-1:0][SumW-1:0]      sum;
    logic                        accept;
    logic                        drain;

    // Handshake outputs depend on state only, so there is no path from out_ready or in_valid.
    assign bus.in_ready  = (state_q != StHold);
    assign bus.out_valid = (state_q == StHold);
    assign bus.out_data  = acc_q;
    assign bus.out_ovf   = ovf_q;

    assign accept = bus.in_valid && (state_q != StHold);
    assign drain  = bus.out_ready && (state_q == StHold);

    always_comb begin
        for (int i = 0; i < N; i++) begin
            sum[i] = {1'b0, acc_q[i]} + SumW'(bus.in_data[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beats_d = beats_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    // A zero beat count is treated as a single-beat group.
                    beats_d = (bus.cfg_beats == '0) ? CntOne : bus.cfg_beats;
                    for (int i = 0; i < N; i++) begin
                        acc_d[i] = ACC_WIDTH'(bus.in_data[i]);
                    end
                    ovf_d   = '0;
                    cnt_d   = CntOne;
                    state_d = (beats_d == CntOne) ? StHold : StAccum;
                end
            end
            StAccum: begin
                if (accept) begin
                    for (int i = 0; i < N; i++) begin
                        if (sum[i][ACC_WIDTH]) begin
                            acc_d[i] = '1;
                            ovf_d[i] = 1'b1;
                        end else begin
                            acc_d[i] = sum[i][ACC_WIDTH-1:0];
                        end
                    end
                    cnt_d = cnt_q + CntOne;
                    if (cnt_d == beats_q) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (drain) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            beats_q <= '0;
            acc_q   <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beats_q <= beats_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule
